// File: rtl/cam_pattern_gen_if.sv
// Camera-link style source bus: control inputs to the generator and the
// frame/line/data valid timing plus packed pixel channels it produces.
interface cam_pattern_gen_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned NUM_CH      = 2
);
  logic                          ce;
  logic                          start;
  logic                          stop;
  logic [1:0]                    mode;
  logic [7:0]                    frame_num;
  logic                          fval;
  logic                          lval;
  logic                          dval;
  logic [NUM_CH*PIXEL_WIDTH-1:0] data;
  logic                          busy;
  logic                          frame_done;
  logic [7:0]                    frame_cnt;

  modport master (
    input  ce, start, stop, mode, frame_num,
    output fval, lval, dval, data, busy, frame_done, frame_cnt
  );

  modport slave (
    output ce, start, stop, mode, frame_num,
    input  fval, lval, dval, data, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/cam_pattern_gen.sv
// Test-pattern video source: FVAL/LVAL/DVAL raster timing with NUM_CH pixel
// channels, N-frame or free-running operation and stop at frame boundary.
module cam_pattern_gen #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HTOTAL      = 360,
  parameter int unsigned VTOTAL      = 492,
  parameter int unsigned HACTIVE     = 320,
  parameter int unsigned VACTIVE     = 480,
  parameter int unsigned CH_OFFSET   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cam_pattern_gen_if.master    bus
);

  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned DW = NUM_CH * PIXEL_WIDTH;
  localparam int unsigned HW = (HTOTAL > 1) ? $clog2(HTOTAL) : 1;
  localparam int unsigned VW = (VTOTAL > 1) ? $clog2(VTOTAL) : 1;
  localparam int unsigned HB = HTOTAL - HACTIVE;
  localparam int unsigned VB = VTOTAL - VACTIVE;
  // coordinate width keeps bit 3 for the 8x8 checker even for narrow pixels
  localparam int unsigned CW = (PIXEL_WIDTH > 4) ? PIXEL_WIDTH : 4;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n;
  logic [PW-1:0]   pix_cnt, pix_n;
  logic [1:0]      mode_r, mode_n;
  logic            stop_req, stop_req_n;
  logic            start_pend, start_pend_n;
  logic [7:0]      frame_cnt, frame_cnt_n;
  logic            fval, fval_n;
  logic            lval, lval_n;
  logic            dval, dval_n;
  logic [DW-1:0]   data, data_n;
  logic            busy, busy_n;
  logic            frame_done, frame_done_n;

  logic            fval_c, lval_c, dval_c, frame_end_c, last_frame_c;
  logic [CW-1:0]   x_c, y_c;
  logic [DW-1:0]   pix_c;

  assign fval_c       = (v_cnt >= VW'(VB));
  assign lval_c       = (h_cnt >= HW'(HB));
  assign dval_c       = fval_c & lval_c;
  assign frame_end_c  = (h_cnt == HW'(HTOTAL - 1)) && (v_cnt == VW'(VTOTAL - 1));
  assign last_frame_c = (bus.frame_num != 8'd0) && ((frame_cnt + 8'd1) == bus.frame_num);
  assign x_c          = CW'(h_cnt) - CW'(HB);
  assign y_c          = CW'(v_cnt) - CW'(VB);

  // Per-channel pixel value for the current raster position
  always_comb begin
    pix_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      case (mode_r)
        2'd0:    pix_c[k*PW +: PW] = pix_cnt + PW'(k * CH_OFFSET);
        2'd1:    pix_c[k*PW +: PW] = dval_c ? x_c[PW-1:0] + PW'(k * CH_OFFSET) : '0;
        2'd3:    pix_c[k*PW +: PW] = dval_c ? y_c[PW-1:0] + PW'(k * CH_OFFSET) : '0;
        default: pix_c[k*PW +: PW] = (dval_c && (x_c[3] ^ y_c[3] ^ k[0])) ? '1 : '0;
      endcase
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    h_n          = h_cnt;
    v_n          = v_cnt;
    pix_n        = pix_cnt;
    mode_n       = mode_r;
    stop_req_n   = stop_req;
    frame_cnt_n  = frame_cnt;
    fval_n       = fval;
    lval_n       = lval;
    dval_n       = dval;
    data_n       = data;
    busy_n       = busy;
    frame_done_n = frame_done;

    // pulses are captured even while the pixel enable is low
    start_pend_n = (state == ST_IDLE) && !bus.ce && (bus.start || start_pend);
    if (bus.stop && ((state == ST_RUN) || bus.start || start_pend)) stop_req_n = 1'b1;

    if (bus.ce) begin
      case (state)
        ST_IDLE: begin
          fval_n       = 1'b0;
          lval_n       = 1'b0;
          dval_n       = 1'b0;
          data_n       = '0;
          busy_n       = 1'b0;
          frame_done_n = 1'b0;
          if (bus.start || start_pend) begin
            state_n     = ST_RUN;
            h_n         = '0;
            v_n         = '0;
            pix_n       = '0;
            frame_cnt_n = '0;
            mode_n      = bus.mode;
          end else begin
            stop_req_n = 1'b0;
          end
        end
        ST_RUN: begin
          fval_n       = fval_c;
          lval_n       = lval_c;
          dval_n       = dval_c;
          data_n       = pix_c;
          busy_n       = 1'b1;
          frame_done_n = 1'b0;
          pix_n        = pix_cnt + PW'(1);
          if (h_cnt == HW'(HTOTAL - 1)) begin
            h_n = '0;
            v_n = (v_cnt == VW'(VTOTAL - 1)) ? '0 : v_cnt + VW'(1);
          end else begin
            h_n = h_cnt + HW'(1);
          end
          if (frame_end_c) begin
            frame_done_n = 1'b1;
            frame_cnt_n  = frame_cnt + 8'd1;
            if (stop_req || bus.stop || last_frame_c) begin
              state_n    = ST_IDLE;
              stop_req_n = 1'b0;
            end else begin
              mode_n = bus.mode;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pix_cnt    <= '0;
      mode_r     <= '0;
      stop_req   <= 1'b0;
      start_pend <= 1'b0;
      frame_cnt  <= '0;
      fval       <= 1'b0;
      lval       <= 1'b0;
      dval       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      h_cnt      <= h_n;
      v_cnt      <= v_n;
      pix_cnt    <= pix_n;
      mode_r     <= mode_n;
      stop_req   <= stop_req_n;
      start_pend <= start_pend_n;
      frame_cnt  <= frame_cnt_n;
      fval       <= fval_n;
      lval       <= lval_n;
      dval       <= dval_n;
      data       <= data_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  assign bus.fval       = fval;
  assign bus.lval       = lval;
  assign bus.dval       = dval;
  assign bus.data       = data;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: directed and randomized scenarios compared per
// cycle against a raster-position reference model.
module tb_cam_pattern_gen;

  localparam int HT = 8, VT = 6, HA = 4, VA = 3, FT = HT * VT, MAXC = 4000;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_t;
  int   dval_seen, fd_seen;

  cam_pattern_gen_if #(.PIXEL_WIDTH(8), .NUM_CH(2)) bus ();

  cam_pattern_gen #(
    .PIXEL_WIDTH(8), .NUM_CH(2), .HTOTAL(HT), .VTOTAL(VT),
    .HACTIVE(HA), .VACTIVE(VA), .CH_OFFSET(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs();
    return 32'({bus.busy, bus.fval, bus.lval, bus.dval, bus.frame_done, bus.frame_cnt, bus.data});
  endfunction

  // Expected outputs after the generator has processed raster step t since START
  function automatic logic [31:0] model(int t, logic [1:0] m);
    int p, h, v, x, y, val;
    logic fv, lv, dv;
    logic [15:0] d;
    p  = t % FT;
    h  = p % HT;
    v  = p / HT;
    fv = (v >= VT - VA);
    lv = (h >= HT - HA);
    dv = fv && lv;
    x  = h - (HT - HA);
    y  = v - (VT - VA);
    d  = '0;
    for (int k = 0; k < 2; k++) begin
      case (m)
        2'd0:    val = t + 16 * k;
        2'd1:    val = dv ? x + 16 * k : 0;
        2'd3:    val = dv ? y + 16 * k : 0;
        default: val = (dv && ((((x >> 3) ^ (y >> 3) ^ k) & 1) == 1)) ? 255 : 0;
      endcase
      d[k*8 +: 8] = 8'(val);
    end
    return 32'({1'b1, fv, lv, dv, (p == FT - 1), 8'((t + 1) / FT), d});
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // One START..IDLE scenario; ce_kind 0 = always on, 1 = toggling, 2 = random
  task automatic run(input string tag, input logic [1:0] ma, input logic [1:0] mb,
                     input int change_t, input int fnum, input int stop_t, input int ce_kind);
    int F, fs, phase, tn, cyc;
    bit issued, stop_done, chg_done, ce_edge, tog;
    logic [1:0] mf;
    fs = (stop_t >= 0) ? stop_t / FT + 1 : 0;
    if (fnum == 0)                     F = fs;
    else if (stop_t >= 0 && fs < fnum) F = fs;
    else                               F = fnum;
    bus.mode      = ma;
    bus.frame_num = 8'(fnum);
    phase = 0; tn = 0; cyc = 0;
    issued = 0; stop_done = 0; chg_done = 0; ce_edge = 0; tog = 1;
    dval_seen = 0; fd_seen = 0;
    while (cyc < MAXC) begin
      @(negedge clk);
      check({tag, " out"}, obs(), exp_t);
      if (ce_edge) begin
        dval_seen += int'(bus.dval);
        fd_seen   += int'(bus.frame_done);
      end
      if (phase == 2) break;
      case (ce_kind)
        0:       bus.ce = 1'b1;
        1:       begin bus.ce = tog; tog = !tog; end
        default: bus.ce = ($urandom_range(0, 3) != 0);
      endcase
      bus.start = !issued || (phase == 1 && tn == 30 && tn < F * FT);
      issued = 1;
      bus.stop = 1'b0;
      if (phase == 1 && tn == stop_t && !stop_done && tn < F * FT) begin
        bus.stop  = 1'b1;
        stop_done = 1;
      end
      if (phase == 1 && tn == change_t && !chg_done) begin
        bus.mode = mb;
        chg_done = 1;
      end
      @(posedge clk);
      ce_edge = bus.ce;
      if (bus.ce) begin
        if (phase == 0) begin
          phase = 1; tn = 0; exp_t = '0;
        end else if (tn == F * FT) begin
          phase = 2;
          exp_t = 32'({1'b0, 4'b0, 8'(F), 16'b0});
        end else begin
          mf    = (change_t >= 0 && change_t < (tn / FT) * FT) ? mb : ma;
          exp_t = model(tn, mf);
          tn++;
        end
      end
      cyc++;
    end
    check({tag, " done"}, 32'(phase), 32'd2);
    check({tag, " dval_count"}, 32'(dval_seen), 32'(HA * VA * F));
    check({tag, " frame_done_count"}, 32'(fd_seen), 32'(F));
    bus.ce = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  initial begin
    int fnum, stop_t, chg;
    logic [1:0] ma, mb;
    rst_n = 1'b0;
    bus.ce = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.mode = 2'd0; bus.frame_num = 8'd0;
    exp_t = '0;
    repeat (3) @(negedge clk);
    check("reset_state", obs(), 32'd0);
    rst_n = 1'b1;

    run("t1_counter_1frame", 2'd0, 2'd0, -1, 1, -1, 0);
    run("t2_hramp_2frames",  2'd1, 2'd1, -1, 2, -1, 0);
    run("t3_free_stop",      2'd2, 2'd2, -1, 0, 2 * FT + 20, 0);
    run("t4_ce_toggle",      2'd0, 2'd0, -1, 1, -1, 1);
    run("t5_mode_change",    2'd1, 2'd3, 20, 2, -1, 0);

    // reset in the middle of a frame aborts with no frame_done
    bus.mode = 2'd0; bus.frame_num = 8'd1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_mid_frame_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_async", obs(), 32'd0);
    @(negedge clk);
    check("t6_reset_hold", obs(), 32'd0);
    rst_n = 1'b1;
    exp_t = '0;
    run("t6_after_reset", 2'd0, 2'd0, -1, 1, -1, 0);

    for (int i = 0; i < 6; i++) begin
      ma   = 2'($urandom_range(0, 3));
      mb   = 2'($urandom_range(0, 3));
      fnum = int'($urandom_range(0, 3));
      chg  = int'($urandom_range(5, FT - 5));
      if (fnum == 0)                   stop_t = int'($urandom_range(0, 2 * FT - 1));
      else if ($urandom_range(0, 1) == 1) stop_t = int'($urandom_range(0, fnum * FT - 1));
      else                             stop_t = -1;
      run("rand", ma, mb, chg, fnum, stop_t, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
